// File: rtl/keypad_hex_entry_if.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_hex_entry_if
//  Description : Bundle of keypad/entry signals shared between the keypad
//                scanner and its environment.
//                  col       keypad column lines, active-low (env -> scanner)
//                  clr       synchronous clear of the entry register
//                  row       keypad row drive, one-hot-low (scanner -> env)
//                  key_valid one-cycle pulse on an accepted press
//                  key_code  hex code of the last accepted key
//                  value     32-bit hex entry register, newest digit in [3:0]
//  Revision    : 1.0 - initial release
// ============================================================================
interface keypad_hex_entry_if;
  logic [3:0]  col;
  logic        clr;
  logic [3:0]  row;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [31:0] value;

  // Environment side (keypad and control).
  modport master (
    output col,
    output clr,
    input  row,
    input  key_valid,
    input  key_code,
    input  value
  );

  // Scanner side.
  modport slave (
    input  col,
    input  clr,
    output row,
    output key_valid,
    output key_code,
    output value
  );
endinterface
`default_nettype wire

// File: rtl/keypad_hex_entry.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_hex_entry
//  Description : Scans a 4x4 active-low matrix keypad one row at a time,
//                debounces press and release, decodes the key to a hex code
//                and shifts each code into a 32-bit entry register.
//  Ports       : clk  - system clock
//                rst  - asynchronous active-high reset
//                bus  - keypad_hex_entry_if.slave (col, clr, row, key_valid,
//                       key_code, value)
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_hex_entry #(
  parameter int SCAN_DIV     = 50000,  // cycles per row, >= 4
  parameter int DEBOUNCE_CNT = 500000  // stable cycles for press/release, >= 2
) (
  input  wire logic           clk,
  input  wire logic           rst,
  keypad_hex_entry_if.slave   bus
);

  localparam int C_DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int C_DEB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(SCAN_DIV - 1);
  localparam logic [C_DEB_W-1:0] C_DEB_LAST = C_DEB_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         col_meta_q, col_s_q;
  logic [C_DIV_W-1:0] div_q, div_d;
  logic [C_DEB_W-1:0] cnt_q, cnt_d;
  logic [3:0]         row_q, row_d;
  logic [3:0]         lat_col_q, lat_col_d;
  logic [1:0]         lat_row_q, lat_row_d;
  logic [3:0]         key_code_q, key_code_d;
  logic [31:0]        value_q, value_d;

  logic [3:0]         w_col_n;
  logic               w_one_low;
  logic [1:0]         w_row_idx;
  logic [1:0]         w_col_idx;
  logic [3:0]         w_code;
  logic [3:0]         w_row_next;

  // Key map indexed by {row index, column index}.
  function automatic logic [3:0] decode(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Exactly one column low: the inverted pattern is a nonzero power of two.
  assign w_col_n    = ~col_s_q;
  assign w_one_low  = (w_col_n != 4'd0) && ((w_col_n & (w_col_n - 4'd1)) == 4'd0);
  assign w_row_next = {row_q[2:0], row_q[3]};

  always_comb begin
    w_row_idx = 2'd0;
    case (row_q)
      4'b1101: w_row_idx = 2'd1;
      4'b1011: w_row_idx = 2'd2;
      4'b0111: w_row_idx = 2'd3;
      default: w_row_idx = 2'd0;
    endcase
  end

  always_comb begin
    w_col_idx = 2'd0;
    case (lat_col_q)
      4'b1101: w_col_idx = 2'd1;
      4'b1011: w_col_idx = 2'd2;
      4'b0111: w_col_idx = 2'd3;
      default: w_col_idx = 2'd0;
    endcase
  end

  assign w_code = decode(lat_row_q, w_col_idx);

  // Two-flop synchronizer; idles high like the pulled-up column lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta_q <= 4'b1111;
      col_s_q    <= 4'b1111;
    end else begin
      col_meta_q <= bus.col;
      col_s_q    <= col_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SCAN;
      div_q      <= '0;
      cnt_q      <= '0;
      row_q      <= 4'b1110;
      lat_col_q  <= 4'b1111;
      lat_row_q  <= 2'd0;
      key_code_q <= 4'd0;
      value_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      lat_col_q  <= lat_col_d;
      lat_row_q  <= lat_row_d;
      key_code_q <= key_code_d;
      value_q    <= value_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    lat_col_d  = lat_col_q;
    lat_row_d  = lat_row_q;
    key_code_d = key_code_q;
    value_d    = value_q;

    case (state_q)
      SCAN: begin
        if (div_q == C_DIV_LAST) begin
          div_d = '0;
          if (w_one_low) begin
            // Freeze the row and watch this exact pattern.
            lat_col_d = col_s_q;
            lat_row_d = w_row_idx;
            cnt_d     = '0;
            state_d   = DEBOUNCE;
          end else begin
            // Idle or ambiguous multi-key pattern: keep scanning.
            row_d = w_row_next;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (col_s_q == lat_col_q) begin
          if (cnt_q == C_DEB_LAST) begin
            // Code is registered on entry so it is visible during the pulse.
            key_code_d = w_code;
            state_d    = PRESSED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          div_d   = '0;
          state_d = SCAN;
        end
      end
      PRESSED: begin
        value_d = {value_q[27:0], key_code_q};
        cnt_d   = '0;
        state_d = RELEASE;
      end
      default: begin // RELEASE
        if (col_s_q == 4'b1111) begin
          if (cnt_q == C_DEB_LAST) begin
            row_d   = w_row_next;
            div_d   = '0;
            state_d = SCAN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
    endcase

    // Clear has priority over a shift in the same cycle.
    if (bus.clr) begin
      value_d = 32'd0;
    end
  end

  assign bus.row       = row_q;
  assign bus.key_valid = (state_q == PRESSED);
  assign bus.key_code  = key_code_q;
  assign bus.value     = value_q;

endmodule
`default_nettype wire
